// File: rtl/regfile_dbg_pkg.sv
// Shared state encoding and default geometry for the register-file debug dumper.
package regfile_dbg_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    // Address reported on the checksum beat (all ones at the default width).
    localparam logic [DEF_ADDR_W-1:0] CKSUM_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SEND,
        S_CKSUM,
        S_DONE
    } dump_state_e;

endpackage

// File: rtl/regfile_debug_dumper.sv
// Drives the register file debug read port and streams the words out over valid/ready.
// Optional checksum beat after a full sweep: define DUMP_CHECKSUM_EN.
module regfile_debug_dumper
    import regfile_dbg_pkg::*;
#(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              dump_all,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_strobe,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Output handshake: a word transfers on a clock edge where out_valid and out_ready
    // are both high; while out_valid is high and out_ready is low the beat is held stable.

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam int                LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_END  = LAT_W'(READ_LATENCY - 1);

    dump_state_e       state;
    dump_state_e       state_next;
    logic              mode_all;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] index_next;
    logic [LAT_W-1:0]  lat_cnt;
    logic              accept_start;
    logic              start_error;
    logic              bad_addr;
    logic              handshake;
    logic              final_idx;
    logic              beat_last;
    logic              capture;

    assign handshake = out_valid && out_ready;
    assign final_idx = (index == LAST_IDX);
    assign bad_addr  = (32'(req_addr) >= NUM_REGS);
    assign capture   = (state == S_WAIT) && (lat_cnt == LAT_END);

`ifdef DUMP_CHECKSUM_EN
    // The checksum beat carries out_last, so no data beat of a sweep does.
    assign beat_last = !mode_all;
`else
    assign beat_last = !mode_all || final_idx;
`endif

    assign out_valid = (state == S_SEND) || (state == S_CKSUM);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        index_next   = index;
        accept_start = 1'b0;
        start_error  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (dump_all) begin
                        index_next   = '0;
                        state_next   = S_ISSUE;
                        accept_start = 1'b1;
                    end else if (bad_addr) begin
                        start_error = 1'b1;
                    end else begin
                        index_next   = req_addr;
                        state_next   = S_ISSUE;
                        accept_start = 1'b1;
                    end
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (lat_cnt == LAT_END) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (handshake) begin
                    if (out_last) begin
                        state_next = S_DONE;
`ifdef DUMP_CHECKSUM_EN
                    end else if (mode_all && final_idx) begin
                        state_next = S_CKSUM;
`endif
                    end else begin
                        index_next = index + 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_CKSUM: begin
                if (handshake) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dbg_addr   <= '0;
            dbg_strobe <= 1'b0;
            error      <= 1'b0;
            mode_all   <= 1'b0;
            index      <= '0;
            lat_cnt    <= '0;
            out_data   <= '0;
            out_addr   <= '0;
            out_last   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            // Strobe is high exactly for the ISSUE cycle; address persists until the next one.
            dbg_strobe <= (state_next == S_ISSUE);
            error      <= start_error;
            index      <= index_next;
            if (state_next == S_ISSUE) begin
                dbg_addr <= index_next;
            end
            if (accept_start) begin
                mode_all <= dump_all;
            end
            if (state == S_ISSUE) begin
                lat_cnt <= '0;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (capture) begin
                out_data <= dbg_data;
                out_addr <= index;
                out_last <= beat_last;
            end
`ifdef DUMP_CHECKSUM_EN
            if (accept_start) begin
                sum <= '0;
            end else if ((state == S_SEND) && handshake) begin
                sum <= sum + out_data;
            end
            // The final sweep word has not been folded into sum yet; add it here.
            if ((state == S_SEND) && (state_next == S_CKSUM)) begin
                out_data <= sum + out_data;
                out_addr <= '1;
                out_last <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_debug_dumper.sv
// Bench for regfile_debug_dumper: table-driven single reads, directed multi-cycle cases,
// and randomized dumps/reads scored against a queue built from the register-file contents.
module tb_regfile_debug_dumper;
    import regfile_dbg_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int LAT      = 1;
    localparam int SMALL_N  = 20;
    localparam int BW       = DATA_W + ADDR_W + 1;
`ifdef DUMP_CHECKSUM_EN
    localparam bit CKSUM = 1'b1;
`else
    localparam bit CKSUM = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              dump_all = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] dbg_data = '0;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_strobe;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              error;

    logic              start20 = 1'b0;
    logic              dump_all20 = 1'b0;
    logic [ADDR_W-1:0] req_addr20 = '0;
    logic              out_ready20 = 1'b1;
    logic [DATA_W-1:0] dbg_data20 = '0;
    logic [ADDR_W-1:0] dbg_addr20;
    logic              dbg_strobe20;
    logic              out_valid20;
    logic [DATA_W-1:0] out_data20;
    logic [ADDR_W-1:0] out_addr20;
    logic              out_last20;
    logic              busy20;
    logic              done20;
    logic              error20;

    regfile_debug_dumper #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                           .READ_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .dump_all(dump_all),
        .req_addr(req_addr), .dbg_addr(dbg_addr), .dbg_strobe(dbg_strobe),
        .dbg_data(dbg_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done), .error(error)
    );

    regfile_debug_dumper #(.NUM_REGS(SMALL_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                           .READ_LATENCY(LAT)) dut20 (
        .clock(clock), .reset(reset), .start(start20), .dump_all(dump_all20),
        .req_addr(req_addr20), .dbg_addr(dbg_addr20), .dbg_strobe(dbg_strobe20),
        .dbg_data(dbg_data20), .out_valid(out_valid20), .out_ready(out_ready20),
        .out_data(out_data20), .out_addr(out_addr20), .out_last(out_last20),
        .busy(busy20), .done(done20), .error(error20)
    );

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [BW-1:0]     exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int str_cnt = 0;
    int str_cnt20 = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int beat_no = 0;
    int last_hs_cyc = 0;
    bit check_spacing = 1'b0;
    bit ready_rand = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Register file model: data appears shortly after the strobe rises.
    always @(posedge dbg_strobe) begin
        str_cnt++;
        #1 dbg_data = mem[dbg_addr];
    end
    always @(posedge dbg_strobe20) begin
        str_cnt20++;
        #1 dbg_data20 = mem[dbg_addr20];
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (ready_rand) out_ready = ($urandom_range(0, 9) < 7);
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic all, input logic [ADDR_W-1:0] a);
        start    = 1'b1;
        dump_all = all;
        req_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_single(input int a);
        exp_q.push_back({mem[a], ADDR_W'(a), 1'b1});
    endtask

    task automatic expect_dump();
        logic [DATA_W-1:0] sum = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_q.push_back({mem[i], ADDR_W'(i), (i == NUM_REGS - 1) && !CKSUM});
            sum += mem[i];
        end
        if (CKSUM) exp_q.push_back({sum, {ADDR_W{1'b1}}, 1'b1});
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run20(input logic [ADDR_W-1:0] a, input logic exp_err);
        int s0 = str_cnt20;
        int n = 0;
        start20    = 1'b1;
        req_addr20 = a;
        tick();
        start20 = 1'b0;
        check("err20_pulse", error20, exp_err);
        check("err20_busy", busy20, !exp_err);
        tick();
        check("err20_clear", error20, 1'b0);
        if (!exp_err) begin
            while (!out_valid20 && n < 20) begin
                tick();
                n++;
            end
            check("beat20", {out_valid20, out_data20, out_addr20, out_last20},
                  {1'b1, mem[a], a, 1'b1});
            repeat (4) tick();
        end
        check("strobes20", 64'(str_cnt20 - s0), exp_err ? 64'd0 : 64'd1);
        check("idle20", busy20, 1'b0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic          prev_stall = 1'b0;
    logic          prev_done = 1'b0;
    logic          prev_strobe = 1'b0;
    logic [BW-1:0] prev_beat = '0;
    logic [BW-1:0] exp_beat;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall  = 1'b0;
            prev_done   = 1'b0;
            prev_strobe = 1'b0;
        end else begin
            if (prev_stall)
                check("hold_beat", {out_valid, out_data, out_addr, out_last}, {1'b1, prev_beat});
            if (dbg_strobe) check("strobe_one_cycle", prev_strobe, 1'b0);
            if (prev_done) check("busy_after_done", busy, 1'b0);
            if (done) begin
                check("done_one_cycle", prev_done, 1'b0);
                done_cnt++;
            end
            if (error) err_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data=%0h addr=%0h last=%0b expected none",
                             out_data, out_addr, out_last);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", {out_data, out_addr, out_last}, exp_beat);
                end
                if (check_spacing && beat_no > 0 && beat_no < NUM_REGS)
                    check("beat_spacing", 64'(cyc - last_hs_cyc), 64'(2 + LAT));
                last_hs_cyc = cyc;
                beat_no++;
            end
            prev_stall  = out_valid && !out_ready;
            prev_beat   = {out_data, out_addr, out_last};
            prev_done   = done;
            prev_strobe = dbg_strobe;
        end
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp_data;
    } rd_vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              exp_err;
    } er_vec_t;

    rd_vec_t rd_tab[4];
    er_vec_t er_tab[5];

    initial begin
        int s0;
        int n;
        int e0;
        logic [ADDR_W-1:0] ra;
        logic              rall;

        rd_tab[0] = '{5'd7,  32'd7};
        rd_tab[1] = '{5'd0,  32'd0};
        rd_tab[2] = '{5'd31, 32'd31};
        rd_tab[3] = '{5'd18, 32'd18};
        er_tab[0] = '{5'd25, 1'b1};
        er_tab[1] = '{5'd20, 1'b1};
        er_tab[2] = '{5'd19, 1'b0};
        er_tab[3] = '{5'd0,  1'b0};
        er_tab[4] = '{5'd31, 1'b1};
        for (int i = 0; i < NUM_REGS; i++) mem[i] = DATA_W'(i);

        // Reset state
        repeat (3) tick();
        check("reset_outputs", {dbg_addr, dbg_strobe, out_valid, out_data, out_addr, out_last,
                                busy, done, error}, 64'd0);
        reset = 1'b0;
        tick();
        check("idle_after_reset", busy, 1'b0);

        // Table-driven single reads
        for (int v = 0; v < 4; v++) begin
            s0 = str_cnt;
            e0 = err_cnt;
            beat_no = 0;
            exp_q.push_back({rd_tab[v].exp_data, rd_tab[v].addr, 1'b1});
            pulse_start(1'b0, rd_tab[v].addr);
            wait_done("single", 50);
            check("single_strobes", 64'(str_cnt - s0), 64'd1);
            check("single_no_error", 64'(err_cnt - e0), 64'd0);
        end

        // Out-of-range single reads on the 20-register instance
        for (int v = 0; v < 5; v++) run20(er_tab[v].addr, er_tab[v].exp_err);

        // Full sweep, consumer always ready: fixed beat spacing
        s0 = str_cnt;
        beat_no = 0;
        check_spacing = 1'b1;
        expect_dump();
        pulse_start(1'b1, '0);
        wait_done("dump", 400);
        check_spacing = 1'b0;
        check("dump_strobes", 64'(str_cnt - s0), 64'(NUM_REGS));

        // Stall at beat 3 with ignored start pulses
        s0 = str_cnt;
        beat_no = 0;
        expect_dump();
        pulse_start(1'b1, '0);
        n = 0;
        while (!(dbg_strobe && dbg_addr == 5'd3) && n < 100) begin
            tick();
            n++;
        end
        check("stall_reach_beat3", 64'(n < 100), 64'd1);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        e0 = str_cnt;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {out_valid, out_data, out_addr}, {1'b1, mem[3], 5'd3});
            start    = (i % 2 == 0);
            dump_all = 1'b0;
            req_addr = 5'd9;
            tick();
        end
        start = 1'b0;
        check("stall_no_strobe", 64'(str_cnt - e0), 64'd0);
        out_ready = 1'b1;
        wait_done("stall_dump", 400);
        check("stall_strobes", 64'(str_cnt - s0), 64'(NUM_REGS));

        // Reset in the middle of beat 10
        beat_no = 0;
        expect_dump();
        pulse_start(1'b1, '0);
        n = 0;
        while (!(out_valid && out_addr == 5'd10) && n < 200) begin
            tick();
            n++;
        end
        check("reach_beat10", 64'(n < 200), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", {dbg_addr, dbg_strobe, out_valid, out_data, out_addr,
                                      out_last, busy, done, error}, 64'd0);
        check("async_reset_state", 64'(dut.state), 64'(S_IDLE));
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("busy_after_abort", busy, 1'b0);
        beat_no = 0;
        expect_dump();
        pulse_start(1'b1, '0);
        wait_done("restart_dump", 400);

        // Randomized requests against the model
        for (int i = 0; i < NUM_REGS; i++) mem[i] = $urandom;
        ready_rand = 1'b1;
        for (int it = 0; it < 24; it++) begin
            rall = ($urandom_range(0, 3) == 0);
            ra   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            beat_no = 0;
            if (rall) expect_dump();
            else expect_single(int'(ra));
            pulse_start(rall, ra);
            wait_done("rand", 2000);
        end
        ready_rand = 1'b0;
        out_ready = 1'b1;
        for (int it = 0; it < 8; it++) begin
            ra = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            run20(ra, (int'(ra) >= SMALL_N));
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
